// File: rtl/disk_chan_arbiter.sv
// disk_chan_arbiter: round-robin owner of the single MCU sector channel shared by two
// disk clients; one grant covers command issue, MCU ack, data phase and release.
module disk_chan_arbiter #(
   parameter int unsigned          TIMEOUT_W = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd16000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [1:0]  wr,
   input  logic [1:0]  drive,
   input  logic [1:0]  head,
   input  logic [13:0] cyl,
   input  logic [15:0] sect,
   input  logic [1:0]  done,
   output logic [1:0]  gnt,
   output logic [1:0]  ack,
   output logic        notfound,
   output logic [31:0] disk_sr,
   input  logic [31:0] disk_cr,
   input  logic        disk_data_clkin,
   input  logic        disk_data_clkout,
   output logic [1:0]  c_data_clkin,
   output logic [1:0]  c_data_clkout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_DATA,
      S_RELEASE
   } state_t;

   localparam logic [TIMEOUT_W-1:0] LP_TO_LAST = TIMEOUT - 1'b1;

   state_t               r_state;
   logic [1:0]           r_gnt;
   logic                 r_last;
   logic                 r_wr;
   logic                 r_drive;
   logic                 r_head;
   logic [6:0]           r_cyl;
   logic [7:0]           r_sect;
   logic [31:0]          r_sr;
   logic [1:0]           r_ack;
   logic                 r_nf;
   logic [TIMEOUT_W-1:0] r_cnt;

   logic w_pick;
   logic w_timeout;
   logic w_unused_cr;

   // On a tie the client that did not win last time is served.
   always_comb begin
      w_pick = req[1];
      if (req == 2'b11) w_pick = ~r_last;
   end

   assign w_timeout   = (TIMEOUT != '0) && (r_cnt == LP_TO_LAST);
   assign w_unused_cr = ^{disk_cr[31:5], disk_cr[2:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_last  <= 1'b1;
         r_wr    <= 1'b0;
         r_drive <= 1'b0;
         r_head  <= 1'b0;
         r_cyl   <= '0;
         r_sect  <= '0;
         r_sr    <= '0;
         r_ack   <= '0;
         r_nf    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_gnt   <= w_pick ? 2'b10 : 2'b01;
                  r_last  <= w_pick;
                  r_wr    <= wr[w_pick];
                  r_drive <= drive[w_pick];
                  r_head  <= head[w_pick];
                  r_cyl   <= w_pick ? cyl[13:7] : cyl[6:0];
                  r_sect  <= w_pick ? sect[15:8] : sect[7:0];
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_sr <= {10'b0,
                        r_wr & r_drive, r_wr & ~r_drive, 1'b0,
                        ~r_wr & r_drive, ~r_wr & ~r_drive, 1'b0,
                        r_head, r_cyl, r_sect};
               r_nf    <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               // A real ack takes priority over a timeout expiring in the same cycle.
               if (disk_cr[4]) begin
                  r_sr[21:16] <= 6'b000001;
                  r_sr[23:22] <= r_gnt;
                  r_nf        <= disk_cr[3];
                  r_ack       <= r_gnt;
                  r_state     <= disk_cr[3] ? S_RELEASE : S_DATA;
               end else if (w_timeout) begin
                  r_sr[21:16] <= '0;
                  r_sr[23:22] <= r_gnt;
                  r_nf        <= 1'b1;
                  r_ack       <= r_gnt;
                  r_state     <= S_RELEASE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (|(done & r_gnt)) r_state <= S_RELEASE;
            end
            S_RELEASE: begin
               if (!disk_cr[4]) begin
                  r_sr[23:16] <= '0;
                  r_gnt       <= '0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt           = r_gnt;
   assign ack           = r_ack;
   assign notfound      = r_nf;
   assign disk_sr       = r_sr;
   assign c_data_clkin  = r_gnt & {2{disk_data_clkin}};
   assign c_data_clkout = r_gnt & {2{disk_data_clkout}};

endmodule
